sbox_layer_ci: RTL

- Parametrised multicycle Nios II custom instruction for the cipher's 4-bit S-box layer.
- Applies the forward or the inverse S-box to every nibble of a DATA_W-bit operand, LANES nibbles per clock.
- Replaces single-nibble inverse-only lookups with one instruction per state word.
- Sits beside the other cipher custom instructions on the CPU custom-instruction port.

---
 rtl/cipher_pkg.sv | 25 ++
 rtl/sbox4_dual.sv | 20 ++
 rtl/sbox_layer_ci.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cipher_pkg.sv
// Shared cipher definitions: 4-bit S-box tables, mode encodings and FSM state type
// used by the custom-instruction blocks on the CPU custom-instruction port.
package cipher_pkg;

  localparam int NIB_W = 4;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hc, 4'h9, 4'hd, 4'h2, 4'h5, 4'hf, 4'h3, 4'h6,
    4'h7, 4'he, 4'h0, 4'h1, 4'ha, 4'h4, 4'hb, 4'h8
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'ha, 4'hb, 4'h3, 4'h6, 4'hd, 4'h4, 4'h7, 4'h8,
    4'hf, 4'h1, 4'hc, 4'he, 4'h0, 4'h2, 4'h9, 4'h5
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sbox_state_e;

endpackage

// File: rtl/sbox4_dual.sv
// Combinational single-nibble S-box, forward or inverse selected by mode.
module sbox4_dual
  import cipher_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       mode,
  output logic [3:0] sub
);

  // Table lookup for the selected direction
  always_comb begin
    sub = 4'h0;
    if (mode == MODE_INV) begin
      sub = SBOX_INV[nib];
    end else begin
      sub = SBOX_FWD[nib];
    end
  end

endmodule

// File: rtl/sbox_layer_ci.sv
// Multicycle custom instruction applying the 4-bit S-box to every nibble of an
// operand, LANES nibbles per enabled clock, rotating results back into place.
module sbox_layer_ci
  import cipher_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);

  localparam int NIB   = DATA_W / NIB_W;
  localparam int STEPS = NIB / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LW    = NIB_W * LANES;

  if ((DATA_W % NIB_W) != 0 || DATA_W > 32 || DATA_W < NIB_W || LANES < 1 ||
      (NIB % LANES) != 0) begin : g_bad_params
    $error("sbox_layer_ci: illegal DATA_W/LANES combination");
  end

  sbox_state_e       state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;

  logic [LW-1:0]     sub_s;
  logic [DATA_W-1:0] shifted_s;
  logic [31:0]       result_ext_s;
  logic              unused_s;

  assign unused_s = ^{datab[31:1], dataa};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox4_dual u_sbox (
      .nib  (work_q[l*NIB_W +: NIB_W]),
      .mode (mode_q),
      .sub  (sub_s[l*NIB_W +: NIB_W])
    );
  end

  // Substituted low lanes re-enter at the top so nibbles return home after STEPS shifts
  if (LW == DATA_W) begin : g_full
    assign shifted_s = sub_s;
  end else begin : g_part
    assign shifted_s = {sub_s, work_q[DATA_W-1:LW]};
  end

  // Zero-extend the finished word to the 32-bit result bus
  always_comb begin
    result_ext_s                = 32'h0;
    result_ext_s[DATA_W-1:0]    = shifted_s;
  end

  // Next-state logic; everything holds while clk_en is low
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    result_d = result_q;
    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_d  = dataa[DATA_W-1:0];
            mode_d  = datab[0];
            cnt_d   = CNT_W'(STEPS - 1);
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          work_d = shifted_s;
          if (cnt_q == {CNT_W{1'b0}}) begin
            result_d = result_ext_s;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      done_d = done_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= {DATA_W{1'b0}};
      mode_q   <= MODE_FWD;
      cnt_q    <= {CNT_W{1'b0}};
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
